// File: rtl/speckle_scan_engine.sv
`default_nettype none
// ============================================================================
// Module   : speckle_scan_engine
// Purpose  : Frame scanner for the speckle sensor array. Walks a one-hot token
//            through the row/column shift chains, fires one ADC conversion per
//            pixel and writes the samples raster-order into frame RAM.
// Options  : SSC_HOT_COUNT_EN - enables the per-frame hot-pixel counter that
//            drives o_hot_count (tied to 0 when undefined).
// Revision : 1.0 - initial release
// ============================================================================
module speckle_scan_engine #(
  parameter  int COLS        = 24,
  parameter  int ROWS        = 24,
  parameter  int NB_DATA     = 12,
  parameter  int NB_FREQ_DIV = 24,
  parameter  int NB_SETTLE   = 8,
  parameter  int ADC_TIMEOUT = 1024,
  localparam int NB_RAM_ADDR = $clog2(COLS*ROWS)
) (
  input  logic                   clk,
  input  logic                   i_rst_n,
  input  logic                   i_start,
  input  logic                   i_continuous,
  input  logic                   i_stop,
  input  logic [NB_FREQ_DIV-1:0] i_clk_div_sr,
  input  logic [NB_SETTLE-1:0]   i_settle,
  input  logic [NB_DATA-1:0]     i_umbral,
  input  logic [NB_DATA-1:0]     i_adc_val,
  input  logic                   i_adc_done,
  output logic                   o_adc_trigger,
  output logic                   o_chip_row_clk,
  output logic                   o_chip_row_rst,
  output logic                   o_chip_row_ena,
  output logic                   o_chip_row_data,
  output logic                   o_chip_col_clk,
  output logic                   o_chip_col_rst,
  output logic                   o_chip_col_data,
  output logic                   o_ram_we,
  output logic [NB_RAM_ADDR-1:0] o_ram_addr,
  output logic [NB_DATA-1:0]     o_ram_data,
  output logic                   o_busy,
  output logic                   o_frame_done,
  output logic                   o_timeout_err,
  output logic [NB_RAM_ADDR:0]   o_hot_count
);

  localparam int NB_COL = $clog2(COLS);
  localparam int NB_ROW = $clog2(ROWS);
  localparam int NB_TO  = $clog2(ADC_TIMEOUT + 1);
  localparam int NB_CNT = (NB_SETTLE > NB_TO) ? NB_SETTLE : NB_TO;

  localparam logic [NB_COL-1:0] c_COL_LAST = NB_COL'(COLS - 1);
  localparam logic [NB_ROW-1:0] c_ROW_LAST = NB_ROW'(ROWS - 1);
  localparam logic [NB_CNT-1:0] c_TO_LAST  = NB_CNT'(ADC_TIMEOUT - 1);

  localparam logic [3:0] c_S_IDLE      = 4'd0;
  localparam logic [3:0] c_S_CHAIN_RST = 4'd1;
  localparam logic [3:0] c_S_ROW_LOAD  = 4'd2;
  localparam logic [3:0] c_S_COL_LOAD  = 4'd3;
  localparam logic [3:0] c_S_SETTLE    = 4'd4;
  localparam logic [3:0] c_S_CONVERT   = 4'd5;
  localparam logic [3:0] c_S_STORE     = 4'd6;
  localparam logic [3:0] c_S_COL_ADV   = 4'd7;
  localparam logic [3:0] c_S_ROW_ADV   = 4'd8;
  localparam logic [3:0] c_S_DONE      = 4'd9;

  logic [3:0]             r_state;
  logic [3:0]             w_next;
  logic [NB_FREQ_DIV-1:0] r_div_cnt;
  logic [NB_FREQ_DIV-1:0] w_div_last;
  logic                   r_phase;
  logic                   w_chain_state;
  logic                   w_tick;
  logic                   w_shift_end;
  logic [NB_CNT-1:0]      r_cnt;
  logic [NB_CNT-1:0]      w_settle_last;
  logic                   w_settle_zero;
  logic                   w_settle_done;
  logic                   w_timeout;
  logic [NB_COL-1:0]      r_col;
  logic [NB_ROW-1:0]      r_row;
  logic [NB_RAM_ADDR-1:0] r_addr;
  logic [NB_DATA-1:0]     r_sample;
  logic                   r_timeout_err;
  logic                   w_col_last;
  logic                   w_row_last;
  logic                   w_run;

  // Chain states are paced by the shift tick; a divider of 0 behaves as 1.
  assign w_chain_state = (r_state == c_S_CHAIN_RST) || (r_state == c_S_ROW_LOAD) ||
                         (r_state == c_S_COL_LOAD)  || (r_state == c_S_COL_ADV)  ||
                         (r_state == c_S_ROW_ADV);
  assign w_div_last    = (i_clk_div_sr == '0) ? '0 : (i_clk_div_sr - NB_FREQ_DIV'(1));
  assign w_tick        = w_chain_state && (r_div_cnt >= w_div_last);
  // Phase 0 = setup (clock low, data valid), phase 1 = clock high.
  assign w_shift_end   = w_tick && r_phase;

  assign w_settle_zero = (i_settle == '0);
  assign w_settle_last = NB_CNT'(i_settle) - NB_CNT'(1);
  assign w_settle_done = w_settle_zero || (r_cnt >= w_settle_last);
  assign w_timeout     = (r_cnt >= c_TO_LAST);
  assign w_col_last    = (r_col == c_COL_LAST);
  assign w_row_last    = (r_row == c_ROW_LAST);
  assign w_run         = !i_stop;

  // State register.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= c_S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state logic; stop beats every other transition.
  always_comb begin
    w_next = r_state;
    if (i_stop) begin
      w_next = c_S_IDLE;
    end else begin
      case (r_state)
        c_S_IDLE:      if (i_start) w_next = c_S_CHAIN_RST;
        c_S_CHAIN_RST: if (w_tick) w_next = c_S_ROW_LOAD;
        c_S_ROW_LOAD:  if (w_shift_end) w_next = c_S_COL_LOAD;
        c_S_COL_LOAD:  if (w_shift_end) w_next = w_settle_zero ? c_S_CONVERT : c_S_SETTLE;
        c_S_SETTLE:    if (w_settle_done) w_next = c_S_CONVERT;
        c_S_CONVERT:   if (i_adc_done || w_timeout) w_next = c_S_STORE;
        c_S_STORE: begin
          if (!w_col_last)      w_next = c_S_COL_ADV;
          else if (!w_row_last) w_next = c_S_ROW_ADV;
          else                  w_next = c_S_DONE;
        end
        c_S_COL_ADV:   if (w_shift_end) w_next = w_settle_zero ? c_S_CONVERT : c_S_SETTLE;
        c_S_ROW_ADV:   if (w_shift_end) w_next = c_S_COL_LOAD;
        c_S_DONE:      w_next = i_continuous ? c_S_CHAIN_RST : c_S_IDLE;
        default:       w_next = c_S_IDLE;
      endcase
    end
  end

  // Pad, strobe and status outputs decoded from the state; stop silences them at once.
  always_comb begin
    o_chip_row_clk  = w_run && ((r_state == c_S_ROW_LOAD) || (r_state == c_S_ROW_ADV)) && r_phase;
    o_chip_row_rst  = w_run && (r_state == c_S_CHAIN_RST);
    o_chip_row_data = w_run && (r_state == c_S_ROW_LOAD);
    o_chip_row_ena  = w_run && !((r_state == c_S_IDLE) || (r_state == c_S_CHAIN_RST) ||
                                 (r_state == c_S_ROW_LOAD));
    o_chip_col_clk  = w_run && ((r_state == c_S_COL_LOAD) || (r_state == c_S_COL_ADV)) && r_phase;
    o_chip_col_rst  = w_run && ((r_state == c_S_CHAIN_RST) ||
                                ((r_state == c_S_ROW_ADV) && !r_phase));
    o_chip_col_data = w_run && (r_state == c_S_COL_LOAD);
    o_adc_trigger   = w_run && (r_state == c_S_CONVERT) && (r_cnt == '0);
    o_ram_we        = w_run && (r_state == c_S_STORE);
    o_frame_done    = w_run && (r_state == c_S_DONE);
    o_busy          = (r_state != c_S_IDLE);
    o_ram_addr      = r_addr;
    o_ram_data      = r_sample;
    o_timeout_err   = r_timeout_err;
  end

  // Shift-tick prescaler and clock phase; both restart on every state change.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
    end else if ((w_next != r_state) || !w_chain_state) begin
      r_div_cnt <= '0;
      r_phase   <= 1'b0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
      r_phase   <= ~r_phase;
    end else begin
      r_div_cnt <= r_div_cnt + NB_FREQ_DIV'(1);
    end
  end

  // Cycle counter shared by settle delay and ADC timeout.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if ((w_next != r_state) ||
                 !((r_state == c_S_SETTLE) || (r_state == c_S_CONVERT))) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + NB_CNT'(1);
    end
  end

  // Pixel position, RAM address, captured sample and sticky timeout flag.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col         <= '0;
      r_row         <= '0;
      r_addr        <= '0;
      r_sample      <= '0;
      r_timeout_err <= 1'b0;
    end else if (w_run) begin
      case (r_state)
        c_S_IDLE: if (i_start) r_timeout_err <= 1'b0;
        c_S_CHAIN_RST: begin
          r_col  <= '0;
          r_row  <= '0;
          r_addr <= '0;
        end
        c_S_CONVERT: begin
          if (i_adc_done) begin
            r_sample <= i_adc_val;
          end else if (w_timeout) begin
            r_sample      <= '0;
            r_timeout_err <= 1'b1;
          end
        end
        c_S_STORE: begin
          if (!w_col_last) begin
            r_col  <= r_col + NB_COL'(1);
            r_addr <= r_addr + NB_RAM_ADDR'(1);
          end else if (!w_row_last) begin
            r_col  <= '0;
            r_row  <= r_row + NB_ROW'(1);
            r_addr <= r_addr + NB_RAM_ADDR'(1);
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SSC_HOT_COUNT_EN
  logic [NB_RAM_ADDR:0] r_hot_run;
  logic [NB_RAM_ADDR:0] r_hot_count;

  // Count samples strictly above threshold; publish the total when the frame completes.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hot_run   <= '0;
      r_hot_count <= '0;
    end else if (w_run) begin
      if (r_state == c_S_CHAIN_RST) begin
        r_hot_run <= '0;
      end else if ((r_state == c_S_STORE) && (r_sample > i_umbral)) begin
        r_hot_run <= r_hot_run + (NB_RAM_ADDR+1)'(1);
      end
      if (r_state == c_S_DONE) r_hot_count <= r_hot_run;
    end
  end

  assign o_hot_count = r_hot_count;
`else
  logic w_unused_umbral;
  assign w_unused_umbral = ^i_umbral;
  assign o_hot_count     = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_speckle_scan_engine.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_speckle_scan_engine
// Purpose  : Scoreboard bench for speckle_scan_engine (4x3 frame, short
//            ADC timeout). Expected RAM writes and hot counts are queued by
//            the stimulus; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_speckle_scan_engine;

  localparam int COLS        = 4;
  localparam int ROWS        = 3;
  localparam int NB_DATA     = 12;
  localparam int NB_FREQ_DIV = 24;
  localparam int NB_SETTLE   = 8;
  localparam int ADC_TIMEOUT = 16;
  localparam int NB_RAM_ADDR = $clog2(COLS*ROWS);
  localparam int NPIX        = COLS*ROWS;
  localparam int ADC_LAT     = 5;

  logic                   clk;
  logic                   i_rst_n;
  logic                   i_start;
  logic                   i_continuous;
  logic                   i_stop;
  logic [NB_FREQ_DIV-1:0] i_clk_div_sr;
  logic [NB_SETTLE-1:0]   i_settle;
  logic [NB_DATA-1:0]     i_umbral;
  logic [NB_DATA-1:0]     i_adc_val;
  logic                   i_adc_done;
  logic                   o_adc_trigger;
  logic                   o_chip_row_clk, o_chip_row_rst, o_chip_row_ena, o_chip_row_data;
  logic                   o_chip_col_clk, o_chip_col_rst, o_chip_col_data;
  logic                   o_ram_we;
  logic [NB_RAM_ADDR-1:0] o_ram_addr;
  logic [NB_DATA-1:0]     o_ram_data;
  logic                   o_busy, o_frame_done, o_timeout_err;
  logic [NB_RAM_ADDR:0]   o_hot_count;

  logic                   adc_done_m;
  logic                   stray_done;
  assign i_adc_done = adc_done_m | stray_done;

  speckle_scan_engine #(
    .COLS(COLS), .ROWS(ROWS), .NB_DATA(NB_DATA), .NB_FREQ_DIV(NB_FREQ_DIV),
    .NB_SETTLE(NB_SETTLE), .ADC_TIMEOUT(ADC_TIMEOUT)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_continuous(i_continuous),
    .i_stop(i_stop), .i_clk_div_sr(i_clk_div_sr), .i_settle(i_settle),
    .i_umbral(i_umbral), .i_adc_val(i_adc_val), .i_adc_done(i_adc_done),
    .o_adc_trigger(o_adc_trigger),
    .o_chip_row_clk(o_chip_row_clk), .o_chip_row_rst(o_chip_row_rst),
    .o_chip_row_ena(o_chip_row_ena), .o_chip_row_data(o_chip_row_data),
    .o_chip_col_clk(o_chip_col_clk), .o_chip_col_rst(o_chip_col_rst),
    .o_chip_col_data(o_chip_col_data),
    .o_ram_we(o_ram_we), .o_ram_addr(o_ram_addr), .o_ram_data(o_ram_data),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_timeout_err(o_timeout_err),
    .o_hot_count(o_hot_count)
  );

  typedef struct {
    int addr;
    int data;
    int lat;
  } wr_t;

  wr_t exp_q[$];
  int  hot_q[$];
  int  total = 0;
  int  bad   = 0;

  // Hand-picked sample tables.
  int base_smp[NPIX] = '{291, 1000, 7, 4094, 2048, 1, 555, 3000, 12, 65, 4000, 200};
  int hot_smp[NPIX]  = '{100, 101, 4095, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  int samples[NPIX];
  int hang_idx   = -1;
  int exp_hi     = 2;
  int exp_settle = 3;

  // Monitor state.
  int cyc = 0, trig_cyc = 0, colfall_cyc = 0;
  int wr_seen = 0, frames_seen = 0;
  int row_rises = 0, cols_in_row = 0, row_hi = 0, col_hi = 0;
  logic prev_row_clk = 1'b0, prev_col_clk = 1'b0, hot_pending = 1'b0;
  int adc_idx = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all_outputs_zero(input string name);
    int any;
    any = int'(o_busy | o_frame_done | o_adc_trigger | o_ram_we | o_timeout_err |
               o_chip_row_clk | o_chip_row_rst | o_chip_row_ena | o_chip_row_data |
               o_chip_col_clk | o_chip_col_rst | o_chip_col_data |
               (|o_ram_addr) | (|o_ram_data) | (|o_hot_count));
    check(name, any, 0);
  endtask

  task automatic push_frame(input int hang, input int npix);
    for (int i = 0; i < npix; i++) begin
      wr_t e;
      e.addr = i;
      e.data = (i == hang) ? 0 : samples[i];
      e.lat  = (i == hang) ? ADC_TIMEOUT : ADC_LAT;
      exp_q.push_back(e);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk); i_start = 1'b1;
    @(negedge clk); i_start = 1'b0;
  endtask

  task automatic wait_frames(input int n, input int budget);
    int k;
    k = 0;
    while (frames_seen < n && k < budget) begin
      @(negedge clk); k++;
    end
    if (frames_seen < n) check("frame_wait_timeout", frames_seen, n);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int k;
    k = 0;
    while (wr_seen < n && k < budget) begin
      @(negedge clk); k++;
    end
    if (wr_seen < n) check("write_wait_timeout", wr_seen, n);
  endtask

  task automatic wait_trigger(input int budget);
    int k;
    k = 0;
    while (!o_adc_trigger && k < budget) begin
      @(negedge clk); k++;
    end
    if (!o_adc_trigger) check("trigger_wait_timeout", 0, 1);
  endtask

  // ADC model: end-of-conversion ADC_LAT cycles after the trigger, except the hang pixel.
  initial begin : adc_model
    int idx;
    adc_done_m = 1'b0;
    i_adc_val  = '0;
    forever begin
      @(negedge clk);
      if (!o_busy) adc_idx = 0;
      if (o_adc_trigger) begin
        idx = adc_idx % NPIX;
        adc_idx++;
        if (idx != hang_idx) begin
          repeat (ADC_LAT - 1) @(negedge clk);
          i_adc_val  = NB_DATA'(samples[idx]);
          adc_done_m = 1'b1;
          @(negedge clk);
          adc_done_m = 1'b0;
          i_adc_val  = '0;
        end
      end
    end
  end

  // Monitor: scoreboard pops, pad timing and frame-level checks.
  always @(negedge clk) begin
    cyc++;
    if (!i_rst_n) begin
      prev_row_clk = 1'b0; prev_col_clk = 1'b0;
      row_hi = 0; col_hi = 0; hot_pending = 1'b0;
    end else begin
      if (hot_pending) begin
        hot_pending = 1'b0;
        check("row_ena_after_done", int'(o_chip_row_ena), 0);
        if (hot_q.size() == 0) check("unexpected_frame_done", 1, 0);
        else check("hot_count", int'(o_hot_count), hot_q.pop_front());
      end
      if (o_chip_row_rst) row_rises = 0;
      if (o_chip_row_clk && !prev_row_clk) begin
        check("row_data_on_rise", int'(o_chip_row_data), int'(row_rises == 0));
        if (row_rises > 0) check("col_clks_per_row", cols_in_row, COLS);
        row_rises++;
        cols_in_row = 0;
        row_hi = 0;
      end
      if (o_chip_row_clk) row_hi++;
      if (!o_chip_row_clk && prev_row_clk) check("row_clk_high", row_hi, exp_hi);
      if (o_chip_col_clk && !prev_col_clk) begin
        cols_in_row++;
        col_hi = 0;
      end
      if (o_chip_col_clk) col_hi++;
      if (!o_chip_col_clk && prev_col_clk) begin
        check("col_clk_high", col_hi, exp_hi);
        colfall_cyc = cyc;
      end
      if (o_adc_trigger) begin
        check("settle_to_trigger", cyc - colfall_cyc, exp_settle);
        trig_cyc = cyc;
      end
      if (o_ram_we) begin
        wr_t e;
        if (exp_q.size() == 0) begin
          check("unexpected_write", int'(o_ram_addr), -1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", int'(o_ram_addr), e.addr);
          check("wr_data", int'(o_ram_data), e.data);
          check("wr_latency", cyc - trig_cyc, e.lat);
        end
        wr_seen++;
      end
      if (o_frame_done) begin
        check("row_clk_rises", row_rises, ROWS);
        check("col_clks_last_row", cols_in_row, COLS);
        check("row_ena_at_done", int'(o_chip_row_ena), 1);
        frames_seen++;
        hot_pending = 1'b1;
      end
      prev_row_clk = o_chip_row_clk;
      prev_col_clk = o_chip_col_clk;
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int wbase;
    i_rst_n = 1'b0; i_start = 1'b0; i_continuous = 1'b0; i_stop = 1'b0;
    i_clk_div_sr = 24'd2; i_settle = 8'd3; i_umbral = 12'd4095;
    stray_done = 1'b0;
    samples = base_smp;

    // Reset state.
    repeat (3) @(negedge clk);
    check_all_outputs_zero("reset_outputs");
    i_rst_n = 1'b1;
    @(negedge clk);
    check_all_outputs_zero("post_reset_outputs");

    // A stray end-of-conversion while idle must not produce a write.
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    repeat (3) @(negedge clk);
    check("idle_stray_done_busy", int'(o_busy), 0);

    // Single frame: raster writes, pad pulses, busy drop.
    push_frame(-1, NPIX);
    hot_q.push_back(0);
    start_pulse();
    check("busy_after_start", int'(o_busy), 1);
    wait_frames(1, 2000);
    repeat (3) @(negedge clk);
    check("busy_after_frame", int'(o_busy), 0);
    check("writes_frame1", wr_seen, NPIX);

    // ADC hangs on pixel 5: zero stored after the timeout, flag sticky until next start.
    hang_idx = 5;
    push_frame(5, NPIX);
    hot_q.push_back(0);
    start_pulse();
    wait_frames(2, 2000);
    repeat (2) @(negedge clk);
    check("timeout_err_set", int'(o_timeout_err), 1);
    hang_idx = -1;
    push_frame(-1, NPIX);
    hot_q.push_back(0);
    start_pulse();
    check("timeout_err_cleared", int'(o_timeout_err), 0);
    wait_frames(3, 2000);
    repeat (3) @(negedge clk);

    // Continuous: three frames, then stop during pixel 7 of the fourth.
    i_continuous = 1'b1;
    wbase = wr_seen;
    for (int f = 0; f < 3; f++) begin
      push_frame(-1, NPIX);
      hot_q.push_back(0);
    end
    push_frame(-1, 7);
    start_pulse();
    wait_writes(wbase + 3*NPIX + 7, 4000);
    wait_trigger(200);
    @(negedge clk);
    i_stop = 1'b1;
    @(negedge clk);
    i_stop = 1'b0;
    i_continuous = 1'b0;
    check("stop_idle_next_cycle", int'(o_busy), 0);
    check("stop_chain_outputs", int'(o_chip_row_clk | o_chip_row_rst | o_chip_row_ena |
                                     o_chip_row_data | o_chip_col_clk | o_chip_col_rst |
                                     o_chip_col_data), 0);
    repeat (60) @(negedge clk);
    check("stop_no_more_writes", wr_seen, wbase + 3*NPIX + 7);
    check("stop_frame_done_count", frames_seen, 6);
    check("stop_queue_drained", exp_q.size(), 0);

    // Hot-pixel count with a strict threshold.
    samples = hot_smp;
    i_umbral = 12'd100;
    push_frame(-1, NPIX);
`ifdef SSC_HOT_COUNT_EN
    hot_q.push_back(2);
`else
    hot_q.push_back(0);
`endif
    start_pulse();
    wait_frames(7, 2000);
    repeat (3) @(negedge clk);

    // Reset in the middle of a conversion, then restart with divider 0.
    samples = base_smp;
    i_umbral = 12'd4095;
    push_frame(-1, NPIX);
    wbase = wr_seen;
    start_pulse();
    wait_writes(wbase + 3, 2000);
    wait_trigger(200);
    @(negedge clk);
    i_rst_n = 1'b0;
    exp_q.delete();
    hot_q.delete();
    @(negedge clk);
    check_all_outputs_zero("midframe_reset_outputs");
    i_clk_div_sr = '0;
    exp_hi = 1;
    repeat (2) @(negedge clk);
    check_all_outputs_zero("midframe_reset_hold");
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    wbase = wr_seen;
    push_frame(-1, NPIX);
    hot_q.push_back(0);
    start_pulse();
    wait_frames(8, 2000);
    repeat (3) @(negedge clk);
    check("restart_writes", wr_seen - wbase, NPIX);
    check("restart_busy_low", int'(o_busy), 0);
    check("final_queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
